// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory responder serving read, write, double (M+M)
// and complement (~M) requests on a 2^ADDR_W x DATA_W memory, with WAIT_CYCLES
// programmable wait states between request accept and execution.
// Optional feature: define MEM_WP_EN to write-protect addresses 0..WP_TOP; a
// modifying op on a protected address leaves memory untouched and sets rsp_err.
// Reset reloads the program image into the memory.
module mem_responder #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1,
   parameter int WP_TOP      = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_DOUBLE = 2'b10;
   localparam logic [1:0] OP_COMPL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EXEC,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic                mem_we;
   logic [DATA_W-1:0]   mem_wval;
   logic [DATA_W-1:0]   cur_word;

   // Program image loaded on reset; addresses beyond the image come up as zero.
   function automatic logic [DATA_W-1:0] image_word(input int idx);
      logic [7:0] b;
      case (idx)
         0:       b = 8'h08;
         1:       b = 8'h18;
         2:       b = 8'h28;
         3:       b = 8'h38;
         4:       b = 8'h48;
         5:       b = 8'h58;
         6:       b = 8'h68;
         7:       b = 8'h89;
         8:       b = 8'h09;
         9:       b = 8'h08;
         10:      b = 8'h08;
         11:      b = 8'h09;
         12:      b = 8'h08;
         13:      b = 8'h08;
         14:      b = 8'h09;
         15:      b = 8'h08;
         default: b = 8'h00;
      endcase
      return DATA_W'(b);
   endfunction

   assign cur_word  = mem_q[addr_q];
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

`ifndef MEM_WP_EN
   logic wp_unused;
   assign wp_unused = (WP_TOP != 0);
`endif

   // Next-state logic: accept in IDLE, count wait states, execute once, hold the response.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mem_we   = 1'b0;
      mem_wval = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
               state_d = (WAIT_CYCLES > 0) ? WAIT : EXEC;
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = EXEC;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         EXEC: begin
            err_d = 1'b0;
            case (op_q)
               OP_READ: begin
                  rdata_d = cur_word;
               end
               OP_WRITE: begin
                  mem_we   = 1'b1;
                  mem_wval = wdata_q;
                  rdata_d  = wdata_q;
               end
               OP_DOUBLE: begin
                  mem_we   = 1'b1;
                  mem_wval = cur_word + cur_word;
                  rdata_d  = cur_word + cur_word;
               end
               OP_COMPL: begin
                  mem_we   = 1'b1;
                  mem_wval = ~cur_word;
                  rdata_d  = ~cur_word;
               end
            endcase
`ifdef MEM_WP_EN
            if ((op_q != OP_READ) && (int'(addr_q) <= WP_TOP)) begin
               mem_we  = 1'b0;
               err_d   = 1'b1;
               rdata_d = cur_word;
            end
`endif
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory update: only the addressed word changes, and only during EXEC.
   always_comb begin
      mem_d = mem_q;
      if (mem_we) begin
         mem_d[addr_q] = mem_wval;
      end
   end

   // State, request latches, response registers and memory; reset reloads the image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= image_word(i);
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven requests with a response scoreboard, plus
// hand-written stall/busy and reset-mid-operation sequences.
module tb_mem_responder;

   localparam int WAIT_CYCLES = 1;

   typedef struct {
      logic [1:0] op;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] expRdata;
      logic       expErr;
   } vec_t;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       rsp_ready = 1'b1;
   logic [1:0] req_op = 2'b00;
   logic [3:0] req_addr = 4'd0;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   int   passCount = 0;
   int   checkCount = 0;
   vec_t vecs[$];
   exp_t sb[$];
   exp_t monExp;

   mem_responder #(
      .ADDR_W(4),
      .DATA_W(8),
      .WAIT_CYCLES(WAIT_CYCLES),
      .WP_TOP(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op(req_op),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic void addVec(input logic [1:0] op, input logic [3:0] addr,
                                  input logic [7:0] wdata, input logic [7:0] er,
                                  input logic ee);
      vec_t v;
      v.op = op;
      v.addr = addr;
      v.wdata = wdata;
      v.expRdata = er;
      v.expErr = ee;
      vecs.push_back(v);
   endfunction

   // Response monitor: every handshake pops and checks one scoreboard entry
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h, expected no response", rsp_rdata);
         end else begin
            monExp = sb.pop_front();
            checkOutput("rsp_rdata", int'(rsp_rdata), int'(monExp.rdata));
            checkOutput("rsp_err", int'(rsp_err), int'(monExp.err));
         end
      end
   end

   // One request: wait for ready, push expectation on accept, check latency
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] addr,
                                input logic [7:0] wdata, input logic [7:0] er,
                                input logic ee);
      int   n;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!rsp_valid && n < 50);
      checkOutput("latency", n, WAIT_CYCLES + 1);
      @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   n;
      exp_t e;

`ifdef MEM_WP_EN
      addVec(2'b00, 4'd7,  8'h00, 8'h89, 1'b0);
      addVec(2'b01, 4'd4,  8'h00, 8'h48, 1'b1);
      addVec(2'b00, 4'd4,  8'h00, 8'h48, 1'b0);
      addVec(2'b10, 4'd0,  8'h00, 8'h08, 1'b1);
      addVec(2'b11, 4'd1,  8'h00, 8'h18, 1'b1);
      addVec(2'b01, 4'd8,  8'hA5, 8'hA5, 1'b0);
      addVec(2'b10, 4'd8,  8'h00, 8'h4A, 1'b0);
      addVec(2'b11, 4'd9,  8'h00, 8'hF7, 1'b0);
      addVec(2'b00, 4'd8,  8'h00, 8'h4A, 1'b0);
`else
      addVec(2'b00, 4'd7,  8'h00, 8'h89, 1'b0);
      addVec(2'b01, 4'd3,  8'hA5, 8'hA5, 1'b0);
      addVec(2'b00, 4'd3,  8'h00, 8'hA5, 1'b0);
      addVec(2'b10, 4'd0,  8'h00, 8'h10, 1'b0);
      addVec(2'b10, 4'd7,  8'h00, 8'h12, 1'b0);
      addVec(2'b00, 4'd7,  8'h00, 8'h12, 1'b0);
      addVec(2'b11, 4'd1,  8'h00, 8'hE7, 1'b0);
      addVec(2'b11, 4'd1,  8'h00, 8'h18, 1'b0);
      addVec(2'b00, 4'd1,  8'h00, 8'h18, 1'b0);
      addVec(2'b01, 4'd15, 8'h3C, 8'h3C, 1'b0);
      addVec(2'b10, 4'd15, 8'h00, 8'h78, 1'b0);
      addVec(2'b11, 4'd8,  8'h00, 8'hF6, 1'b0);
      addVec(2'b00, 4'd8,  8'h00, 8'hF6, 1'b0);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", int'(req_ready), 1);
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_rsp_rdata", int'(rsp_rdata), 0);
      checkOutput("reset_rsp_err", int'(rsp_err), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata,
                       vecs[i].expRdata, vecs[i].expErr);
      end

      // Stall in RESP with a competing request held on the request channel
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_addr  = 4'd5;
      @(posedge clk);
      e.rdata = 8'h58;
      e.err   = 1'b0;
      sb.push_back(e);
      #1 req_addr = 4'd2;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      checkOutput("stall_rsp_seen", int'(rsp_valid), 1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_rsp_valid", int'(rsp_valid), 1);
         checkOutput("stall_rsp_rdata", int'(rsp_rdata), 'h58);
         checkOutput("stall_req_ready", int'(req_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 50);
      checkOutput("busy_req_ready", int'(req_ready), 1);
      @(posedge clk);
      e.rdata = 8'h28;
      e.err   = 1'b0;
      sb.push_back(e);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sb.size() != 0 && n < 50);
      @(posedge clk);

      // Reset during WAIT of a write: request abandoned, image restored
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_addr  = 4'd2;
      req_wdata = 8'hFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_rsp_valid", int'(rsp_valid), 0);
      checkOutput("rstmid_req_ready", int'(req_ready), 1);
      checkOutput("rstmid_rsp_rdata", int'(rsp_rdata), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("rstmid_no_rsp", int'(rsp_valid), 0);
      end
      applyStimulus(2'b00, 4'd2, 8'h00, 8'h28, 1'b0);
      applyStimulus(2'b00, 4'd7, 8'h00, 8'h89, 1'b0);
      applyStimulus(2'b00, 4'd3, 8'h00, 8'h38, 1'b0);

      checkOutput("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder side of the accumulator CPU's memory interface: a 2^ADDR_W x DATA_W memory serving read, write and in-place read-modify-write requests.
- Covers the CPU's memory-side operations: fetch/load, store, double (M+M) and complement (~M).
- Valid/ready request and response channels; programmable wait states model slow memory.
- Sits between the CPU core and its program/data store; reset reloads the program image.

Parameters:
- ADDR_W, 4, address width; depth = 2^ADDR_W.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, wait states inserted between request accept and execution (0..15).
- WP_TOP, 7, highest write-protected address; used only when MEM_WP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_op  in  2  00 read, 01 write, 10 double, 11 complement.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data; used for op 01 only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  result data.
- rsp_err  out  1  protection error; constant 0 when MEM_WP_EN is not defined.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - Memory reloads the image 08,18,28,38,48,58,68,89,09,08,08,09,08,08,09,08 (hex, addresses 0..15). Any higher addresses reload to 0.
- States: IDLE, WAIT, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid && req_ready: latch op, addr and wdata.
  - Next state is WAIT if WAIT_CYCLES > 0, else EXEC.
- WAIT:
  - Counter runs from 0; after WAIT_CYCLES edges, go to EXEC.
  - Request inputs are ignored here.
- EXEC, a single cycle, then RESP:
  - read: rdata = M[a].
  - write: M[a] = wdata; rdata = wdata.
  - double: M[a] = (M[a] + M[a]) mod 2^DATA_W; rdata = new value.
  - complement: M[a] = ~M[a]; rdata = new value.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake, rsp_valid drops and the state returns to IDLE.
- Latency: for a request accepted at edge k, rsp_valid is high after edge k + WAIT_CYCLES + 1.
- Throughput: req_ready is low in WAIT, EXEC and RESP. With rsp_ready held high, the minimum request spacing is WAIT_CYCLES + 3 cycles.
- Busy behaviour: req_valid while req_ready = 0 is not accepted; no queueing.
- rsp_ready held low: stall in RESP indefinitely, all outputs held.
- Addresses are always in range; arithmetic wraps modulo 2^DATA_W with no carry out.
- Reset mid-operation: abandons the request, with no response issued.
  - Reset before the EXEC edge: no memory modification.
  - The memory image reload overrides any prior write in either case.
- rsp_rdata keeps its last value in IDLE.

Optional Feature:
- Macro: MEM_WP_EN.
- Defined:
  - Write, double and complement to address <= WP_TOP do not modify memory.
  - The response carries rsp_err = 1 and rsp_rdata = the unchanged M[a].
  - Reads are never errors.
  - rsp_err = 0 for all other responses.
- Undefined: no protection; rsp_err tied to 0; WP_TOP unused.

Test Plan:
1. Reset, WAIT_CYCLES = 1, read addr 7 accepted at edge k -> rsp_valid high after edge k+2, rsp_rdata = 0x89, rsp_err = 0.
2. Write addr 3 = 0xA5, then read addr 3 -> write response rdata 0xA5; read returns 0xA5. Without MEM_WP_EN.
3. Double addr 0 (0x08) -> 0x10. Double addr 7 (0x89) -> 0x12 (wrap). A subsequent read of 7 returns 0x12.
4. Complement addr 1 (0x18) -> rsp 0xE7. A second complement restores 0x18.
5. Stall and busy handling:
   - Hold rsp_ready low 5 cycles -> rsp_valid and rsp_rdata held for all 5, req_ready = 0.
   - A concurrent req_valid read of addr 2 is not accepted until after the response handshake.
6. Reset and protection:
   - Assert rst during WAIT of write addr 2 = 0xFF -> rsp_valid = 0, read of addr 2 returns 0x28.
   - With MEM_WP_EN and WP_TOP = 7, write addr 4 = 0x00 -> rsp_err = 1, rsp_rdata = 0x48, memory unchanged.
